// File: rtl/sec_display_pkg.sv
// Shared constants and the 7-segment encoder for the seconds counter demo.
// Latency: none (constants and a pure function).
// Backpressure: none; nothing here holds state.
package sec_display_pkg;

   localparam int COUNT_W = 8;
   localparam int LED_W   = 12;

   // All segments off, decimal point off (active-low).
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Active-low {dp,g,f,e,d,c,b,a}; dp is always off. Values above 9 blank.
   function automatic logic [7:0] seg_encode(input logic [3:0] digit);
      logic [7:0] seg;
      case (digit)
         4'd0:    seg = 8'hC0;
         4'd1:    seg = 8'hF9;
         4'd2:    seg = 8'hA4;
         4'd3:    seg = 8'hB0;
         4'd4:    seg = 8'h99;
         4'd5:    seg = 8'h92;
         4'd6:    seg = 8'h82;
         4'd7:    seg = 8'hF8;
         4'd8:    seg = 8'h80;
         4'd9:    seg = 8'h90;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// One 7-segment digit: BCD digit plus enable in, registered active-low segments out.
// Latency: 1 cycle from digit/enable to segment output.
// Backpressure: none; reloads every cycle.
module seg7_decode
   import sec_display_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_resetn,
   input  logic [3:0] i_digit,
   input  logic       i_en,
   output logic [7:0] o_seg
);

   logic [7:0] r_seg;

   // Segment register: blank while disabled or in reset, otherwise the encoded digit.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_seg <= SEG_BLANK;
      end else if (i_en) begin
         r_seg <= seg_encode(i_digit);
      end else begin
         r_seg <= SEG_BLANK;
      end
   end

   assign o_seg = r_seg;

endmodule

// File: rtl/sec_counter_display.sv
// Tick-driven 8-bit counter shown in decimal on three 7-segment digits, plus a rotating LED.
// Latency: count changes on the tick edge; segments follow count/disp_en one cycle later.
// Backpressure: none; cnt_en low on a tick drops that increment with no catch-up.
module sec_counter_display
   import sec_display_pkg::*;
#(
   parameter int TICK_CYCLES = 50_000_000,
   parameter int LED_STEP    = 5_000_000
)
(
   input  logic               clk,
   input  logic               resetn,
   input  logic               cnt_en,
   input  logic               disp_en,
   output logic [COUNT_W-1:0] count,
   output logic               tick,
   output logic [LED_W-1:0]   led,
   output logic [7:0]         seg0,
   output logic [7:0]         seg1,
   output logic [7:0]         seg2
);

   localparam int TW = $clog2(TICK_CYCLES);
   localparam int LW = $clog2(LED_STEP);

   logic [TW-1:0]      r_tick_pre;
   logic [LW-1:0]      r_led_pre;
   logic [COUNT_W-1:0] r_count;
   logic [LED_W-1:0]   r_led;
   logic               w_tick;
   logic               w_led_step;
   logic [3:0]         w_ones;
   logic [3:0]         w_tens;
   logic [3:0]         w_hund;

   // Tick is decoded from the prescaler, so it is low in reset (prescaler at 0).
   assign w_tick     = (r_tick_pre == TW'(TICK_CYCLES - 1));
   assign w_led_step = (r_led_pre == LW'(LED_STEP - 1));

   // Tick prescaler: free-running 0..TICK_CYCLES-1, ignores cnt_en.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_tick_pre <= '0;
      end else if (w_tick) begin
         r_tick_pre <= '0;
      end else begin
         r_tick_pre <= r_tick_pre + TW'(1);
      end
   end

   // Counter: advances on enabled ticks, wraps naturally at 256.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_count <= '0;
      end else if (w_tick && cnt_en) begin
         r_count <= r_count + COUNT_W'(1);
      end
   end

   // LED prescaler: independent free-running 0..LED_STEP-1.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_led_pre <= '0;
      end else if (w_led_step) begin
         r_led_pre <= '0;
      end else begin
         r_led_pre <= r_led_pre + LW'(1);
      end
   end

   // LED rotator: one-hot pattern rotates left once per LED step.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_led <= LED_W'(1);
      end else if (w_led_step) begin
         r_led <= {r_led[LED_W-2:0], r_led[LED_W-1]};
      end
   end

   // Decimal split of the current count; hundreds is at most 2.
   assign w_ones = 4'(r_count % 8'd10);
   assign w_tens = 4'((r_count / 8'd10) % 8'd10);
   assign w_hund = 4'(r_count / 8'd100);

   seg7_decode u_seg0 (
      .i_clk    (clk),
      .i_resetn (resetn),
      .i_digit  (w_ones),
      .i_en     (disp_en),
      .o_seg    (seg0)
   );

   seg7_decode u_seg1 (
      .i_clk    (clk),
      .i_resetn (resetn),
      .i_digit  (w_tens),
      .i_en     (disp_en),
      .o_seg    (seg1)
   );

   seg7_decode u_seg2 (
      .i_clk    (clk),
      .i_resetn (resetn),
      .i_digit  (w_hund),
      .i_en     (disp_en),
      .o_seg    (seg2)
   );

   assign count = r_count;
   assign tick  = w_tick;
   assign led   = r_led;

endmodule

// File: tb/tb_sec_counter_display.sv
// Randomized bench for sec_counter_display against an edge-counting reference model.
// Latency: model predicts outputs for each cycle from edges elapsed since reset release.
// Backpressure: not applicable.
module tb_sec_counter_display;

   localparam int TC = 4;
   localparam int LS = 3;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cnt_en;
   logic        disp_en;
   logic [7:0]  count;
   logic        tick;
   logic [11:0] led;
   logic [7:0]  seg0;
   logic [7:0]  seg1;
   logic [7:0]  seg2;

   int errors = 0;
   int checks = 0;

   // Reference model state: edges since release, count, and the segment triple last loaded.
   int          m_j     = 0;
   int          m_count = 0;
   logic [23:0] m_seg   = 24'hFFFFFF;

   sec_counter_display #(.TICK_CYCLES(TC), .LED_STEP(LS)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .cnt_en  (cnt_en),
      .disp_en (disp_en),
      .count   (count),
      .tick    (tick),
      .led     (led),
      .seg0    (seg0),
      .seg1    (seg1),
      .seg2    (seg2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] enc(input int d);
      case (d)
         0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
         4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
         8: return 8'h80;  9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [23:0] segs(input int v, input logic en);
      if (!en) return 24'hFFFFFF;
      return {enc(v / 100), enc((v / 10) % 10), enc(v % 10)};
   endfunction

   // Model: tick during cycle j iff j%TC==TC-1; segments capture the pre-edge count.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_j     = 0;
         m_count = 0;
         m_seg   = 24'hFFFFFF;
      end else begin
         m_seg = segs(m_count, disp_en);
         if ((m_j % TC) == TC - 1 && cnt_en) m_count = (m_count + 1) % 256;
         m_j++;
      end
   end

   // Compare every output against the model once per cycle, away from the active edge.
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         chk("tick",   32'(tick),  32'((m_j % TC) == TC - 1));
         chk("count",  32'(count), 32'(m_count));
         chk("led",    32'(led),   32'(1) << ((m_j / LS) % 12));
         chk("onehot", 32'($countones(led)), 32'd1);
         chk("seg2",   32'(seg2),  32'(m_seg[23:16]));
         chk("seg1",   32'(seg1),  32'(m_seg[15:8]));
         chk("seg0",   32'(seg0),  32'(m_seg[7:0]));
      end
   end

   // Run with random cnt_en until the model reaches target, then check literal digits.
   task automatic reach(input int target, input logic [7:0] e2, input logic [7:0] e1,
                        input logic [7:0] e0);
      int n = 0;
      while (m_count != target && n < 3000) begin
         @(negedge clk);
         cnt_en = ($urandom_range(0, 7) != 0);
         n++;
      end
      if (n >= 3000) begin
         errors++;
         checks++;
         $display("FAIL reach_timeout: count %0d never reached %0d", m_count, target);
      end else begin
         @(negedge clk);
         chk($sformatf("lit_cnt_%0d", target), 32'(count), 32'(target));
         chk($sformatf("lit_s2_%0d", target), 32'(seg2), 32'(e2));
         chk($sformatf("lit_s1_%0d", target), 32'(seg1), 32'(e1));
         chk($sformatf("lit_s0_%0d", target), 32'(seg0), 32'(e0));
      end
   endtask

   initial begin
      int saved;
      int ticks;
      resetn  = 1'b0;
      cnt_en  = 1'b0;
      disp_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;

      // First cycle after release is blank; the next shows 000.
      @(negedge clk);
      @(negedge clk);
      chk("rel_seg2", 32'(seg2), 32'hC0);
      chk("rel_seg1", 32'(seg1), 32'hC0);
      chk("rel_seg0", 32'(seg0), 32'hC0);

      // Digit sweep and wrap, pinned by hand-computed segment triples.
      for (int d = 1; d <= 9; d++) reach(d, 8'hC0, 8'hC0, enc(d));
      reach(10,  8'hC0, 8'hF9, 8'hC0);
      reach(99,  8'hC0, 8'h90, 8'h90);
      reach(100, 8'hF9, 8'hC0, 8'hC0);
      reach(123, 8'hF9, 8'hA4, 8'hB0);
      reach(200, 8'hA4, 8'hC0, 8'hC0);
      reach(255, 8'hA4, 8'h92, 8'h92);
      reach(0,   8'hC0, 8'hC0, 8'hC0);

      // cnt_en low across three ticks: count frozen, tick keeps pulsing.
      @(negedge clk);
      cnt_en = 1'b0;
      saved  = m_count;
      ticks  = 0;
      repeat (3 * TC) begin
         @(negedge clk);
         if (tick === 1'b1) ticks++;
      end
      chk("hold_count", 32'(count), 32'(saved));
      chk("hold_ticks", 32'(ticks), 32'd3);

      // Display off blanks next cycle while counting continues.
      cnt_en  = 1'b1;
      disp_en = 1'b0;
      @(negedge clk);
      chk("blank_seg0", 32'(seg0), 32'hFF);
      chk("blank_seg2", 32'(seg2), 32'hFF);
      repeat (3 * TC) @(negedge clk);
      chk("blank_counts", 32'(count), 32'((saved + 3) % 256));
      disp_en = 1'b1;
      @(negedge clk);

      // Random enables.
      repeat (400) begin
         @(negedge clk);
         cnt_en  = ($urandom_range(0, 3) != 0);
         disp_en = ($urandom_range(0, 4) != 0);
      end

      // Asynchronous reset between edges, visible before any clock edge.
      @(posedge clk);
      #3 resetn = 1'b0;
      #1;
      chk("ares_count", 32'(count), 32'd0);
      chk("ares_tick",  32'(tick),  32'd0);
      chk("ares_led",   32'(led),   32'h001);
      chk("ares_seg0",  32'(seg0),  32'hFF);
      chk("ares_seg1",  32'(seg1),  32'hFF);
      chk("ares_seg2",  32'(seg2),  32'hFF);
      @(posedge clk);
      #1 resetn = 1'b1;
      cnt_en  = 1'b1;
      disp_en = 1'b1;

      // Prescalers restart from 0: literal tick and LED positions.
      for (int k = 0; k <= 40; k++) begin
         @(negedge clk);
         if (k == 3) begin
            chk("rst_tick3", 32'(tick), 32'd1);
            chk("rst_led3",  32'(led),  32'h002);
         end
         if (k == 33) chk("rst_led33", 32'(led), 32'h800);
         if (k == 36) chk("rst_led36", 32'(led), 32'h001);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
